// File: rtl/smart_toilet_ctrl_pkg.sv
// Shared definitions for the smart_toilet reagent dispense controller:
// FSM state encodings and inlet bit positions on the pump/valve buses.
package smart_toilet_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t RUN   = 2'd1;
  localparam state_t DRAIN = 2'd2;

  localparam int unsigned SOLN1 = 0;
  localparam int unsigned SOLN2 = 1;
  localparam int unsigned SOLN3 = 2;

endpackage

// File: rtl/smart_toilet_dispense_ctrl_if.sv
// Command channel of the dispense controller: one command per valid/ready
// handshake, carrying per-inlet stroke counts and the stroke period.
interface smart_toilet_dispense_ctrl_if #(
  parameter int unsigned VOL_W = 8,
  parameter int unsigned PER_W = 16
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [VOL_W-1:0] cmd_vol1;
  logic [VOL_W-1:0] cmd_vol2;
  logic [VOL_W-1:0] cmd_vol3;
  logic [PER_W-1:0] cmd_period;

  modport master (
    output cmd_valid, cmd_vol1, cmd_vol2, cmd_vol3, cmd_period,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_vol1, cmd_vol2, cmd_vol3, cmd_period,
    output cmd_ready
  );

endinterface

// File: rtl/stroke_timer.sv
// Stroke period counter: counts 0..period-1 while enabled and flags the
// last count of each period as a one-cycle tick. period must be >= 1.
module stroke_timer #(
  parameter int unsigned PER_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [PER_W-1:0] period,
  output logic             tick
);

  logic [PER_W-1:0] cnt_q;

  assign tick = en && (cnt_q == (period - PER_W'(1)));

  // Period counter: cleared on load, wraps after the tick.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tick ? '0 : cnt_q + PER_W'(1);
    end
  end

endmodule

// File: rtl/smart_toilet_dispense_ctrl.sv
// Reagent dispense sequencer for the three smart_toilet inlets. soln3 starts
// first, soln2 LEAD_32 strokes later and soln1 a further LEAD_21 strokes later,
// so slugs from the long serpentine chains reach the mixers together.
// A fixed drain interval follows before done is pulsed.
module smart_toilet_dispense_ctrl
  import smart_toilet_ctrl_pkg::*;
#(
  parameter int unsigned VOL_W         = 8,
  parameter int unsigned PER_W         = 16,
  parameter int unsigned LEAD_32       = 6,
  parameter int unsigned LEAD_21       = 4,
  parameter int unsigned DRAIN_STROKES = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  smart_toilet_dispense_ctrl_if.slave  cmd,
  input  logic                         abort,
  output logic [2:0]                   pump_step,
  output logic [2:0]                   valve_open,
  output logic                         busy,
  output logic                         done,
  output logic                         aborted
);

  localparam int unsigned SW = VOL_W + 2;
  typedef logic [SW-1:0] sidx_t;

  localparam sidx_t OFF3       = '0;
  localparam sidx_t OFF2       = sidx_t'(LEAD_32);
  localparam sidx_t OFF1       = sidx_t'(LEAD_32 + LEAD_21);
  localparam sidx_t DRAIN_LAST = sidx_t'(DRAIN_STROKES - 1);

  state_t           state_q;
  sidx_t            s_q;
  logic [VOL_W-1:0] vol1_q, vol2_q, vol3_q;
  logic [PER_W-1:0] per_q;

  logic             accept;
  logic             tick;
  logic [2:0]       act;
  sidx_t            e1, e2, e3, end_s;
  logic             last_run;

  function automatic logic in_win(input sidx_t s, input sidx_t off,
                                  input logic [VOL_W-1:0] vol);
    return (vol != '0) && (s >= off) && (s < (off + sidx_t'(vol)));
  endfunction

  assign cmd.cmd_ready = (state_q == IDLE) && !rst;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign busy          = (state_q != IDLE);

  stroke_timer #(
    .PER_W (PER_W)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (accept),
    .en     (busy),
    .period (per_q),
    .tick   (tick)
  );

  // Inlet windows relative to the stroke index and the end of the last window.
  always_comb begin
    act        = '0;
    act[SOLN1] = in_win(s_q, OFF1, vol1_q);
    act[SOLN2] = in_win(s_q, OFF2, vol2_q);
    act[SOLN3] = in_win(s_q, OFF3, vol3_q);
    e1         = OFF1 + sidx_t'(vol1_q);
    e2         = OFF2 + sidx_t'(vol2_q);
    e3         = OFF3 + sidx_t'(vol3_q);
    end_s      = '0;
    if (vol3_q != '0) end_s = e3;
    if ((vol2_q != '0) && (e2 > end_s)) end_s = e2;
    if ((vol1_q != '0) && (e1 > end_s)) end_s = e1;
    last_run   = (s_q == (end_s - sidx_t'(1)));
  end

  assign valve_open = (state_q == RUN) ? act : 3'b000;
  assign pump_step  = ((state_q == RUN) && tick) ? act : 3'b000;

  // Sequencer: accept, stroke through the windows, drain, complete or abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      vol1_q  <= '0;
      vol2_q  <= '0;
      vol3_q  <= '0;
      per_q   <= PER_W'(1);
      done    <= 1'b0;
      aborted <= 1'b0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            vol1_q  <= cmd.cmd_vol1;
            vol2_q  <= cmd.cmd_vol2;
            vol3_q  <= cmd.cmd_vol3;
            per_q   <= (cmd.cmd_period == '0) ? PER_W'(1) : cmd.cmd_period;
            s_q     <= '0;
            state_q <= ((cmd.cmd_vol1 | cmd.cmd_vol2 | cmd.cmd_vol3) == '0)
                       ? DRAIN : RUN;
          end
        end
        RUN: begin
          if (abort) begin
            state_q <= IDLE;
            aborted <= 1'b1;
          end else if (tick) begin
            if (last_run) begin
              state_q <= DRAIN;
              s_q     <= '0;
            end else begin
              s_q <= s_q + sidx_t'(1);
            end
          end
        end
        DRAIN: begin
          // abort takes priority over the final drain tick
          if (abort) begin
            state_q <= IDLE;
            aborted <= 1'b1;
          end else if (tick) begin
            if (s_q == DRAIN_LAST) begin
              state_q <= IDLE;
              done    <= 1'b1;
            end else begin
              s_q <= s_q + sidx_t'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/smart_toilet_dispense_ctrl.md
# smart_toilet_dispense_ctrl

Reagent dispense sequencer that drives the three inlet pumps/valves (soln1, soln2, soln3) of the smart_toilet_r fluidic netlist. It accepts one dispense command at a time, with a per-inlet stroke count and a stroke period. It then issues pump strokes in staggered windows so that slugs travelling the long serpentine chains (soln3, soln2) arrive at the mixers aligned with soln1. A drain interval follows before completion is signalled. This is the electrical control end of the fluidic interface the netlist consumes.

## Interface
Parameters:
- VOL_W, 8: width of per-inlet stroke counts.
- PER_W, 16: width of stroke period (clock cycles per stroke).
- LEAD_32, 6: strokes by which the soln3 window leads the soln2 window. Must be < 2^VOL_W.
- LEAD_21, 4: strokes by which the soln2 window leads the soln1 window. Must be < 2^VOL_W.
- DRAIN_STROKES, 8: idle strokes after the last pump stroke. Must be ≥1.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE (and not in rst).
- cmd_vol1, cmd_vol2, cmd_vol3  in  VOL_W each  stroke counts per inlet; 0 means the inlet is skipped.
- cmd_period  in  PER_W  cycles per stroke; 0 is treated as 1.
- abort  in  1  cancel the current command.
- pump_step  out  3  one-cycle stroke pulse per inlet; bit0=soln1, bit1=soln2, bit2=soln3.
- valve_open  out  3  level; inlet window active.
- busy  out  1  state ≠ IDLE.
- done  out  1  one-cycle pulse on normal completion.
- aborted  out  1  one-cycle pulse on abort.

## Operation
- FSM states: IDLE, RUN, DRAIN.
- Accept: cmd_valid && cmd_ready on the edge at cycle T.
  - Latch vols and period (0 → 1); clear the period counter and stroke index s.
  - Go to RUN, or to DRAIN if all three vols are 0.
- Tick: the period counter counts 0..P-1 and wraps. tick = (count == P-1). The first tick is at cycle T+P.
- Inlet windows, as stroke offsets:
  - OFF3 = 0.
  - OFF2 = LEAD_32.
  - OFF1 = LEAD_32+LEAD_21.
  - Inlet i is active while OFF_i ≤ s < OFF_i+vol_i.
- RUN:
  - On each tick, pump_step[i] = 1 for every active inlet.
  - valve_open[i] = active(i) as a level; it is 0 outside RUN.
  - s increments on every tick.
  - END = max(OFF_i+vol_i) over inlets with vol_i ≠ 0.
  - On the tick where s == END-1: go to DRAIN and clear s.
- DRAIN: no pumping. On the DRAIN_STROKES-th tick, go to IDLE and pulse done in the following cycle. cmd_ready is high in that same cycle.
- abort in RUN or DRAIN:
  - Next cycle: IDLE, valves closed, aborted=1, no done.
  - A pump_step coincident with the abort cycle is still emitted.
  - abort in IDLE is ignored.
- cmd_valid outside IDLE is ignored; there is no queuing.
- Arithmetic: s and END are VOL_W+2 bits wide and cannot overflow for legal parameters. The period counter is PER_W bits.

## Timing
- Reset values: state=IDLE; cmd_ready=1 (0 while rst is asserted); pump_step=0; valve_open=0; busy=0; done=0; aborted=0.
- pump_step and tick are combinational from registered state. valve_open, busy and cmd_ready are decodes of registered state. done and aborted are registered.
- Accept-to-first-stroke latency: P cycles.
- rst asserted mid-RUN: outputs reach reset values at the next edge and the command is discarded.
- Simultaneous abort and final DRAIN tick: abort wins, so aborted=1 and done=0.
- P=1: a stroke occurs every cycle, and windows are contiguous pulses.

## Structure
- Package smart_toilet_ctrl_pkg:
  - state enum {IDLE, RUN, DRAIN}.
  - Inlet index constants SOLN1=0, SOLN2=1, SOLN3=2.
- Sub-module stroke_timer: period counter with load/clear and a tick output, parameterised by PER_W.
- Window comparators and the FSM live in the top module.

## Test plan
- Defaults; vol3=2, vol2=1, vol1=1, period=4; accept at cycle 0:
  - pump_step[2] at cycles 4 and 8; pump_step[1] at 28; pump_step[0] at 44.
  - DRAIN ticks at cycles 48–76; done at cycle 77.
- All vols 0, period=2: no pump_step; DRAIN 8 ticks at cycles 2–16; done at 17.
- period=0, vol1=3, others 0: treated as period 1. pump_step[0] at cycles 11, 12, 13 (s=10..12); valve_open[0] is high throughout those cycles.
- abort at cycle 20 of the first scenario: aborted at 21, busy=0 at 21, no done, no further pump_step. A new command is accepted at 21.
- cmd_valid held high during RUN with different vols: not accepted, and outputs are unchanged vs. the first scenario. rst at cycle 30: all outputs reset at 31.
- abort on the same cycle as the final DRAIN tick: aborted=1, done never pulses.
